// File: rtl/switch_arbiter_if.sv
// Request/grant/select bundle between the input-buffer request logic,
// the arbiter and the crossbar of one 5-port router tile.
interface switch_arbiter_if;
    logic [2:0] request_L;
    logic [2:0] request_N;
    logic [2:0] request_E;
    logic [2:0] request_S;
    logic [2:0] request_W;
    logic       grant_L;
    logic       grant_N;
    logic       grant_E;
    logic       grant_S;
    logic       grant_W;
    logic [2:0] sel_L;
    logic [2:0] sel_N;
    logic [2:0] sel_E;
    logic [2:0] sel_S;
    logic [2:0] sel_W;
    logic [4:0] out_busy;

    modport master (
        output request_L, request_N, request_E, request_S, request_W,
        input  grant_L, grant_N, grant_E, grant_S, grant_W,
        input  sel_L, sel_N, sel_E, sel_S, sel_W,
        input  out_busy
    );

    modport slave (
        input  request_L, request_N, request_E, request_S, request_W,
        output grant_L, grant_N, grant_E, grant_S, grant_W,
        output sel_L, sel_N, sel_E, sel_S, sel_W,
        output out_busy
    );
endinterface

// File: rtl/switch_arbiter.sv
// Per-output round-robin arbiter with ownership locking for a 5-port switch.
// Optional hold limit: define SWITCH_ARB_HOLD_LIMIT_EN to enable MAX_HOLD expiry.
module switch_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic           clk,
    input  logic           rst,
    switch_arbiter_if.slave arb
);

    localparam logic [2:0] FREE  = 3'd7;
    localparam logic [2:0] PTR_R = 3'd4;

`ifdef SWITCH_ARB_HOLD_LIMIT_EN
    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
`endif

    // Input requests, index order L,N,E,S,W
    logic [4:0][2:0] req;
    // rmask[o][i] = input i requests output o
    logic [4:0][4:0] rmask;

    logic [4:0][2:0] owner_q, owner_d;
    logic [4:0][2:0] ptr_q, ptr_d;
    logic [4:0]      grant_q, grant_d;
    logic [4:0]      busy_q, busy_d;
`ifdef SWITCH_ARB_HOLD_LIMIT_EN
    logic [4:0][7:0] cnt_q, cnt_d;
`endif

    assign req = {arb.request_W, arb.request_S, arb.request_E,
                  arb.request_N, arb.request_L};

    // First set bit of m scanning p+1, p+2, ... mod 5; FREE if none
    function automatic logic [2:0] rr_pick(input logic [4:0] m,
                                           input logic [2:0] p);
        logic [3:0] idx;
        logic [2:0] w;
        w = FREE;
        for (int k = 5; k >= 1; k--) begin
            idx = {1'b0, p} + 4'(k);
            if (idx >= 4'd5) idx = idx - 4'd5;
            if (m[idx[2:0]]) w = idx[2:0];
        end
        return w;
    endfunction

    // Decode each input's destination into per-output requester sets
    always_comb begin
        rmask = '0;
        for (int o = 0; o < 5; o++) begin
            for (int i = 0; i < 5; i++) begin
                rmask[o][i] = (req[i] == 3'(o));
            end
        end
    end

    // Per-output ownership update and registered grant/busy next values
    always_comb begin
        logic [4:0] oh;
        logic       held;
        logic [2:0] w;
`ifdef SWITCH_ARB_HOLD_LIMIT_EN
        logic [4:0] others;
        others  = '0;
        cnt_d   = cnt_q;
`endif
        owner_d = owner_q;
        ptr_d   = ptr_q;
        grant_d = '0;
        busy_d  = '0;
        oh      = '0;
        held    = 1'b0;
        w       = FREE;
        for (int o = 0; o < 5; o++) begin
            oh   = 5'b00001 << owner_q[o];
            held = |(rmask[o] & oh);
            if (held) begin
`ifdef SWITCH_ARB_HOLD_LIMIT_EN
                others = rmask[o] & ~oh;
                if (cnt_q[o] >= HOLD_LIM && others != '0) begin
                    w          = rr_pick(others, ptr_q[o]);
                    owner_d[o] = w;
                    ptr_d[o]   = w;
                    cnt_d[o]   = 8'd1;
                end else if (cnt_q[o] != 8'hFF) begin
                    cnt_d[o] = cnt_q[o] + 8'd1;
                end
`endif
            end else begin
                w          = rr_pick(rmask[o], ptr_q[o]);
                owner_d[o] = w;
                if (w != FREE) begin
                    ptr_d[o] = w;
`ifdef SWITCH_ARB_HOLD_LIMIT_EN
                    cnt_d[o] = 8'd1;
`endif
                end else begin
`ifdef SWITCH_ARB_HOLD_LIMIT_EN
                    cnt_d[o] = 8'd0;
`endif
                end
            end
        end
        for (int o = 0; o < 5; o++) begin
            busy_d[o] = (owner_d[o] != FREE);
            for (int i = 0; i < 5; i++) begin
                if (rmask[o][i] && owner_d[o] == 3'(i)) grant_d[i] = 1'b1;
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= {5{FREE}};
            ptr_q   <= {5{PTR_R}};
            grant_q <= '0;
            busy_q  <= '0;
`ifdef SWITCH_ARB_HOLD_LIMIT_EN
            cnt_q   <= '0;
`endif
        end else begin
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
`ifdef SWITCH_ARB_HOLD_LIMIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign arb.grant_L  = grant_q[0];
    assign arb.grant_N  = grant_q[1];
    assign arb.grant_E  = grant_q[2];
    assign arb.grant_S  = grant_q[3];
    assign arb.grant_W  = grant_q[4];
    assign arb.sel_L    = owner_q[0];
    assign arb.sel_N    = owner_q[1];
    assign arb.sel_E    = owner_q[2];
    assign arb.sel_S    = owner_q[3];
    assign arb.sel_W    = owner_q[4];
    assign arb.out_busy = busy_q;

endmodule

// File: tb/tb_switch_arbiter.sv
// Scoreboard bench for switch_arbiter: expected grant/sel/busy words are
// queued with each stimulus step and compared one cycle later.
module tb_switch_arbiter;

    logic clk;
    logic rst;
    int   tests;
    int   failed;

    switch_arbiter_if bus();

    switch_arbiter #(.MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .arb (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  g;
        logic [14:0] s;
        logic [4:0]  b;
    } exp_t;

    typedef struct {
        logic        rst;
        logic [14:0] req;
        exp_t        e;
        string       nm;
    } step_t;

    exp_t sbq[$];

    localparam logic [14:0] ALLF = 15'h7FFF;

    function automatic logic [14:0] v5(input logic [2:0] l,
        input logic [2:0] n, input logic [2:0] e,
        input logic [2:0] s, input logic [2:0] w);
        return {w, s, e, n, l};
    endfunction

    function automatic step_t mk(input logic r, input logic [14:0] rq,
        input logic [4:0] g, input logic [14:0] s,
        input logic [4:0] b, input string nm);
        step_t t;
        t.rst = r;
        t.req = rq;
        t.e.g = g;
        t.e.s = s;
        t.e.b = b;
        t.nm  = nm;
        return t;
    endfunction

    task automatic set_req(input logic [14:0] r);
        bus.request_L = r[2:0];
        bus.request_N = r[5:3];
        bus.request_E = r[8:6];
        bus.request_S = r[11:9];
        bus.request_W = r[14:12];
    endtask

    function automatic logic [24:0] sample();
        return {bus.grant_W, bus.grant_S, bus.grant_E, bus.grant_N,
                bus.grant_L,
                bus.sel_W, bus.sel_S, bus.sel_E, bus.sel_N, bus.sel_L,
                bus.out_busy};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        set_req(ALLF);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        step_t st[$];
        exp_t  ex;
        logic [24:0] obs;
        st.push_back(mk(1, ALLF, 5'b0, ALLF, 5'b0, "reset_c1"));
        st.push_back(mk(1, ALLF, 5'b0, ALLF, 5'b0, "reset_c2"));
        foreach (st[k]) begin
            rst = st[k].rst;
            set_req(st[k].req);
            sbq.push_back(st[k].e);
            @(posedge clk);
            #1;
            ex  = sbq.pop_front();
            obs = sample();
            tests++;
            if (obs !== {ex.g, ex.s, ex.b}) begin
                failed++;
                $display("FAIL %s: got g=%b sel=%o busy=%b want g=%b sel=%o busy=%b",
                         st[k].nm, obs[24:20], obs[19:5], obs[4:0],
                         ex.g, ex.s, ex.b);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        step_t st[$];
        exp_t  ex;
        logic [24:0] obs;
        do_reset();
        st.push_back(mk(0, v5(7,7,7,7,0), 5'b10000, v5(4,7,7,7,7),
                        5'b00001, "single_grant"));
        st.push_back(mk(0, v5(7,7,7,7,0), 5'b10000, v5(4,7,7,7,7),
                        5'b00001, "single_hold"));
        st.push_back(mk(0, ALLF, 5'b0, ALLF, 5'b0, "single_release"));
        st.push_back(mk(0, v5(0,7,7,7,7), 5'b00001, v5(0,7,7,7,7),
                        5'b00001, "loopback"));
        st.push_back(mk(0, v5(6,5,7,6,5), 5'b0, ALLF, 5'b0,
                        "nonreq_codes"));
        foreach (st[k]) begin
            rst = st[k].rst;
            set_req(st[k].req);
            sbq.push_back(st[k].e);
            @(posedge clk);
            #1;
            ex  = sbq.pop_front();
            obs = sample();
            tests++;
            if (obs !== {ex.g, ex.s, ex.b}) begin
                failed++;
                $display("FAIL %s: got g=%b sel=%o busy=%b want g=%b sel=%o busy=%b",
                         st[k].nm, obs[24:20], obs[19:5], obs[4:0],
                         ex.g, ex.s, ex.b);
            end
        end
    endtask

    task automatic test_contention();
        step_t st[$];
        exp_t  ex;
        logic [24:0] obs;
        do_reset();
        st.push_back(mk(0, v5(2,2,2,7,7), 5'b00001, v5(7,7,0,7,7),
                        5'b00100, "cont_L_first"));
        st.push_back(mk(0, v5(2,2,2,7,7), 5'b00001, v5(7,7,0,7,7),
                        5'b00100, "cont_L_lock"));
        st.push_back(mk(0, v5(7,2,2,7,7), 5'b00010, v5(7,7,1,7,7),
                        5'b00100, "cont_hand_N"));
        st.push_back(mk(0, v5(2,7,2,7,7), 5'b00100, v5(7,7,2,7,7),
                        5'b00100, "cont_hand_E"));
        st.push_back(mk(0, v5(2,7,7,7,7), 5'b00001, v5(7,7,0,7,7),
                        5'b00100, "cont_wrap_L"));
        foreach (st[k]) begin
            rst = st[k].rst;
            set_req(st[k].req);
            sbq.push_back(st[k].e);
            @(posedge clk);
            #1;
            ex  = sbq.pop_front();
            obs = sample();
            tests++;
            if (obs !== {ex.g, ex.s, ex.b}) begin
                failed++;
                $display("FAIL %s: got g=%b sel=%o busy=%b want g=%b sel=%o busy=%b",
                         st[k].nm, obs[24:20], obs[19:5], obs[4:0],
                         ex.g, ex.s, ex.b);
            end
        end
    endtask

    task automatic test_independent();
        step_t st[$];
        exp_t  ex;
        logic [24:0] obs;
        do_reset();
        st.push_back(mk(0, v5(7,3,0,2,7), 5'b01110, v5(2,7,3,1,7),
                        5'b01101, "indep_three"));
        st.push_back(mk(0, v5(4,3,0,2,1), 5'b11111, v5(2,4,3,1,0),
                        5'b11111, "indep_all_five"));
        foreach (st[k]) begin
            rst = st[k].rst;
            set_req(st[k].req);
            sbq.push_back(st[k].e);
            @(posedge clk);
            #1;
            ex  = sbq.pop_front();
            obs = sample();
            tests++;
            if (obs !== {ex.g, ex.s, ex.b}) begin
                failed++;
                $display("FAIL %s: got g=%b sel=%o busy=%b want g=%b sel=%o busy=%b",
                         st[k].nm, obs[24:20], obs[19:5], obs[4:0],
                         ex.g, ex.s, ex.b);
            end
        end
    endtask

    task automatic test_hold_limit();
        step_t st[$];
        exp_t  ex;
        logic [24:0] obs;
        logic        l_turn;
        do_reset();
        for (int c = 0; c < 12; c++) begin
`ifdef SWITCH_ARB_HOLD_LIMIT_EN
            l_turn = ((c / 4) % 2) == 0;
`else
            l_turn = 1'b1;
`endif
            if (l_turn)
                st.push_back(mk(0, v5(1,7,7,7,1), 5'b00001,
                                v5(7,0,7,7,7), 5'b00010,
                                $sformatf("hold_c%0d", c)));
            else
                st.push_back(mk(0, v5(1,7,7,7,1), 5'b10000,
                                v5(7,4,7,7,7), 5'b00010,
                                $sformatf("hold_c%0d", c)));
        end
        foreach (st[k]) begin
            rst = st[k].rst;
            set_req(st[k].req);
            sbq.push_back(st[k].e);
            @(posedge clk);
            #1;
            ex  = sbq.pop_front();
            obs = sample();
            tests++;
            if (obs !== {ex.g, ex.s, ex.b}) begin
                failed++;
                $display("FAIL %s: got g=%b sel=%o busy=%b want g=%b sel=%o busy=%b",
                         st[k].nm, obs[24:20], obs[19:5], obs[4:0],
                         ex.g, ex.s, ex.b);
            end
        end
    endtask

    task automatic test_dest_change();
        step_t st[$];
        exp_t  ex;
        logic [24:0] obs;
        do_reset();
        st.push_back(mk(0, v5(1,7,7,7,7), 5'b00001, v5(7,0,7,7,7),
                        5'b00010, "dest_own_N"));
        st.push_back(mk(0, v5(2,7,7,7,7), 5'b00001, v5(7,7,0,7,7),
                        5'b00100, "dest_move_E"));
        st.push_back(mk(0, v5(2,7,7,7,3), 5'b10001, v5(7,7,0,4,7),
                        5'b01100, "dest_add_WS"));
        st.push_back(mk(1, v5(2,7,7,7,3), 5'b0, ALLF, 5'b0,
                        "mid_reset"));
        st.push_back(mk(0, v5(2,7,7,7,3), 5'b10001, v5(7,7,0,4,7),
                        5'b01100, "post_reset"));
        foreach (st[k]) begin
            rst = st[k].rst;
            set_req(st[k].req);
            sbq.push_back(st[k].e);
            @(posedge clk);
            #1;
            ex  = sbq.pop_front();
            obs = sample();
            tests++;
            if (obs !== {ex.g, ex.s, ex.b}) begin
                failed++;
                $display("FAIL %s: got g=%b sel=%o busy=%b want g=%b sel=%o busy=%b",
                         st[k].nm, obs[24:20], obs[19:5], obs[4:0],
                         ex.g, ex.s, ex.b);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        rst    = 1'b1;
        set_req(ALLF);
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_contention();
        test_independent();
        test_hold_limit();
        test_dest_change();
        if (sbq.size() != 0) begin
            tests++;
            failed++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
